// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants for the cache line mover: command opcodes, completion
// status codes, AXI response/burst encodings and the FSM state encoding.
// Also holds the helper that folds an AXI response into a running status.
// -----------------------------------------------------------------------------
package cache_pkg;

    // Command opcodes on cmd_op
    localparam logic CMD_FILL = 1'b0;
    localparam logic CMD_WB   = 1'b1;

    // Completion status codes on done_status
    localparam logic [1:0] STAT_OK     = 2'b00;
    localparam logic [1:0] STAT_SLVERR = 2'b10;
    localparam logic [1:0] STAT_PROT   = 2'b01;

    // AXI encodings used by the surrounding cache_top tie-offs
    localparam logic [1:0] AXI_OKAY = 2'b00;
    localparam logic [1:0] AXI_INCR = 2'b01;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_R    = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Fold one AXI response into the running status: the first non-OKAY
    // response becomes a slave error, and an already recorded error sticks.
    function automatic logic [1:0] stat_merge(input logic [1:0] cur, input logic [1:0] resp);
        logic [1:0] res;
        if (cur != STAT_OK) begin
            res = cur;
        end else if (resp != AXI_OKAY) begin
            res = STAT_SLVERR;
        end else begin
            res = STAT_OK;
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_line_buf.sv
// -----------------------------------------------------------------------------
// cache_line_buf
// One cache line held as LINE_WORDS x DATA_W registers plus a beat counter.
// The counter selects the word written by a read beat and the word presented
// on the write channel.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clr           zero the line and the counter (start of a fill)
//   i_load          load i_line and zero the counter (start of a write-back)
//   i_wr, i_wdata   write i_wdata to word[counter], then advance
//   i_adv           advance the counter without writing (write beat sent)
//   o_line          whole line, word 0 in the low bits
//   o_word          word[counter]
//   o_cnt           current beat counter
// -----------------------------------------------------------------------------
module cache_line_buf #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_load,
    input  logic [LINE_WORDS*DATA_W-1:0] i_line,
    input  logic                         i_wr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic                         i_adv,
    output logic [LINE_WORDS*DATA_W-1:0] o_line,
    output logic [DATA_W-1:0]            o_word,
    output logic [CNT_W-1:0]             o_cnt
);

    logic [DATA_W-1:0] r_words [LINE_WORDS];
    logic [CNT_W-1:0]  r_cnt;

    // Line storage and beat counter; clear/load take priority over beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= {DATA_W{1'b0}};
            end
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= {DATA_W{1'b0}};
            end
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= i_line[i*DATA_W +: DATA_W];
            end
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_wr) begin
            r_words[r_cnt] <= i_wdata;
            r_cnt          <= r_cnt + CNT_W'(1);
        end else if (i_adv) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Flatten the word array onto the line bus.
    always_comb begin
        o_line = {(LINE_WORDS*DATA_W){1'b0}};
        for (int i = 0; i < LINE_WORDS; i++) begin
            o_line[i*DATA_W +: DATA_W] = r_words[i];
        end
    end

    assign o_word = r_words[r_cnt];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/cache_line_mover.sv
// -----------------------------------------------------------------------------
// cache_line_mover
// Line fill / write-back engine between the cache core and the memory
// controller. A fill issues one LINE_WORDS-beat AXI3 INCR read burst; a
// write-back issues one AW + LINE_WORDS-beat W burst and waits for B.
// Ports:
//   cclk, cresetn                 clock, asynchronous active-low reset
//   cmd_*                         line command (valid/ready, op, addr, wline)
//   done_valid/rline/status       one-cycle completion, held data/status
//   cm_ar*, mc_r*                 AXI read address / read data channels
//   cm_aw*, cm_w*, mc_b*          AXI write address / data / response channels
// -----------------------------------------------------------------------------
module cache_line_mover
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                         cclk,
    input  logic                         cresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_op,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] cmd_wline,
    output logic                         done_valid,
    output logic [LINE_WORDS*DATA_W-1:0] done_rline,
    output logic [1:0]                   done_status,
    output logic                         cm_arvalid,
    input  logic                         cm_arready,
    output logic [ADDR_W-1:0]            cm_araddr,
    input  logic                         mc_rvalid,
    output logic                         mc_rready,
    input  logic [DATA_W-1:0]            mc_rdata,
    input  logic [1:0]                   mc_rresp,
    input  logic                         mc_rlast,
    output logic                         cm_awvalid,
    input  logic                         cm_awready,
    output logic [ADDR_W-1:0]            cm_awaddr,
    output logic                         cm_wvalid,
    input  logic                         cm_wready,
    output logic [DATA_W-1:0]            cm_wdata,
    output logic                         cm_wlast,
    input  logic                         mc_bvalid,
    output logic                         mc_bready,
    input  logic [1:0]                   mc_bresp
);

    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_stat;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_done_valid;
    logic [LINE_W-1:0] r_done_rline;
    logic [1:0]        r_done_status;

    logic              w_accept;
    logic              w_buf_clr;
    logic              w_buf_load;
    logic              w_buf_wr;
    logic              w_buf_adv;
    logic [LINE_W-1:0] w_buf_line;
    logic [DATA_W-1:0] w_buf_word;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_last_beat;
    logic              w_rd_end;
    logic [1:0]        w_rd_stat;
    logic [LINE_W-1:0] w_fill_line;
    logic              w_aw_fin;
    logic              w_w_fin;

    cache_line_buf #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .CNT_W      (CNT_W)
    ) u_buf (
        .i_clk   (cclk),
        .i_rst_n (cresetn),
        .i_clr   (w_buf_clr),
        .i_load  (w_buf_load),
        .i_line  (cmd_wline),
        .i_wr    (w_buf_wr),
        .i_wdata (mc_rdata),
        .i_adv   (w_buf_adv),
        .o_line  (w_buf_line),
        .o_word  (w_buf_word),
        .o_cnt   (w_cnt)
    );

    // Handshake decode, burst termination and read status for this cycle.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) & cmd_valid;
        w_buf_clr   = w_accept & (cmd_op == CMD_FILL);
        w_buf_load  = w_accept & (cmd_op == CMD_WB);
        w_buf_wr    = r_rready & mc_rvalid;
        w_buf_adv   = r_wvalid & cm_wready;
        w_last_beat = (w_cnt == LAST);
        // A read burst ends on rlast or on the last expected beat, whichever first.
        w_rd_end    = w_buf_wr & (mc_rlast | w_last_beat);
        // rlast must coincide with the last beat; any mismatch is a protocol error.
        if (mc_rlast != w_last_beat) begin
            w_rd_stat = STAT_PROT;
        end else begin
            w_rd_stat = stat_merge(r_stat, mc_rresp);
        end
        // Line as it will look once the current beat is stored, so done_rline
        // can be captured on the same edge as the final beat.
        w_fill_line = w_buf_line;
        w_fill_line[int'(w_cnt)*DATA_W +: DATA_W] = mc_rdata;
        // AW and the last W beat may finish in either order or together.
        w_aw_fin    = r_aw_done | (r_awvalid & cm_awready);
        w_w_fin     = r_w_done | (w_buf_adv & w_last_beat);
    end

    // Main sequencer: IDLE -> AR|WR -> R|B -> DONE -> IDLE.
    always_ff @(posedge cclk or negedge cresetn) begin
        if (!cresetn) begin
            r_state       <= ST_IDLE;
            r_addr        <= {ADDR_W{1'b0}};
            r_stat        <= STAT_OK;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_done_valid  <= 1'b0;
            r_done_rline  <= {LINE_W{1'b0}};
            r_done_status <= STAT_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr    <= cmd_addr & ~OFF_MASK;
                        r_stat    <= STAT_OK;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (cmd_op == CMD_FILL) begin
                            r_state   <= ST_AR;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state   <= ST_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (cm_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_rd_end) begin
                        r_rready      <= 1'b0;
                        r_done_valid  <= 1'b1;
                        r_done_rline  <= w_fill_line;
                        r_done_status <= w_rd_stat;
                        r_state       <= ST_DONE;
                    end else if (w_buf_wr) begin
                        r_stat <= w_rd_stat;
                    end
                end
                ST_WR: begin
                    if (r_awvalid && cm_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_buf_adv && w_last_beat) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (mc_bvalid) begin
                        r_bready      <= 1'b0;
                        r_done_valid  <= 1'b1;
                        r_done_status <= stat_merge(r_stat, mc_bresp);
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign done_valid  = r_done_valid;
    assign done_rline  = r_done_rline;
    assign done_status = r_done_status;
    assign cm_arvalid  = r_arvalid;
    assign cm_araddr   = r_addr;
    assign mc_rready   = r_rready;
    assign cm_awvalid  = r_awvalid;
    assign cm_awaddr   = r_addr;
    assign cm_wvalid   = r_wvalid;
    assign cm_wdata    = w_buf_word;
    assign cm_wlast    = r_wvalid & w_last_beat;
    assign mc_bready   = r_bready;

endmodule
